// File: rtl/seq_sched_rr.sv
// seq_sched_rr: round-robin owner arbitration in front of one shared 4-phase one-hot sequencer.
// Latency: req sampled -> gnt/seq_start after 1 edge; nominal pass holds gnt 5 cycles, then done pulses 1 cycle.
// Backpressure: requesters hold level req; nothing is granted while an operation or an error is outstanding.
module seq_sched_rr #(
  parameter int  N_REQ   = 4,
  parameter int  TIMEOUT = 15,
  localparam int IDW     = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] done,
  output logic [IDW-1:0]   owner_id,
  output logic             seq_start,
  input  logic [3:0]       seq_phase,
  output logic             busy,
  output logic             err,
  input  logic             err_clr
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [3:0] P1 = 4'b1000;
  localparam logic [3:0] P2 = 4'b0100;

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN, ERROR} state_t;

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [TW-1:0]  tcnt;
  logic [3:0]     last_phase;

  logic             win_vld;
  logic [IDW-1:0]   win_idx;
  logic [IDW-1:0]   cand;
  logic [N_REQ-1:0] win_onehot;
  logic [3:0]       next_phase;
  logic             stall_expired;
  logic [IDW-1:0]   ptr_after;

  // Pick the first requester at or above rr_ptr, wrapping around the requester ring.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDW'((int'(rr_ptr) + k) % N_REQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Derived helpers: one-hot grant vector, legal next phase, stall limit, and pointer after completion.
  always_comb begin
    win_onehot          = '0;
    win_onehot[win_idx] = win_vld;
    next_phase          = {last_phase[0], last_phase[3:1]};
    stall_expired       = (int'(tcnt) + 1) >= TIMEOUT;
    ptr_after           = (owner_id == IDW'(N_REQ - 1)) ? '0 : owner_id + IDW'(1);
  end

  // Scheduler FSM: all outputs are registered and updated together with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= '0;
      done       <= '0;
      owner_id   <= '0;
      seq_start  <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      rr_ptr     <= '0;
      tcnt       <= '0;
      last_phase <= P1;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            gnt        <= win_onehot;
            owner_id   <= win_idx;
            seq_start  <= 1'b1;
            busy       <= 1'b1;
            tcnt       <= '0;
            last_phase <= P1;
            state      <= LAUNCH;
          end
        end

        LAUNCH: begin
          if (seq_phase == P1) begin
            // Sequencer has not picked up the start yet; keep start asserted and count.
            if (stall_expired) begin
              tcnt      <= TW'(TIMEOUT);
              gnt       <= '0;
              seq_start <= 1'b0;
              busy      <= 1'b0;
              err       <= 1'b1;
              state     <= ERROR;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end else if (seq_phase == P2) begin
            seq_start  <= 1'b0;
            last_phase <= P2;
            tcnt       <= '0;
            state      <= RUN;
          end else begin
            gnt       <= '0;
            seq_start <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b1;
            state     <= ERROR;
          end
        end

        RUN: begin
          if (seq_phase == last_phase) begin
            if (stall_expired) begin
              tcnt  <= TW'(TIMEOUT);
              gnt   <= '0;
              busy  <= 1'b0;
              err   <= 1'b1;
              state <= ERROR;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end else if (seq_phase == next_phase) begin
            tcnt       <= '0;
            last_phase <= seq_phase;
            // Returning to P1 after P4 closes the pass and hands the token on.
            if (seq_phase == P1) begin
              done   <= gnt;
              gnt    <= '0;
              busy   <= 1'b0;
              rr_ptr <= ptr_after;
              state  <= IDLE;
            end
          end else begin
            gnt   <= '0;
            busy  <= 1'b0;
            err   <= 1'b1;
            state <= ERROR;
          end
        end

        ERROR: begin
          // Sticky until explicitly cleared; pending requests wait for the IDLE cycle after the clear.
          if (err_clr) begin
            err   <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_sched_rr.sv
// tb_seq_sched_rr: randomized scoreboard bench for seq_sched_rr with a behavioural sequencer.
// Expected grant/done/error events are queued by the stimulus and consumed by a negedge monitor.
// The reference arbiter is a plain ring search over the request word from the model's pointer.
module tb_seq_sched_rr;

  localparam int N  = 4;
  localparam int TO = 15;

  localparam logic [3:0] P1 = 4'b1000;
  localparam logic [3:0] P2 = 4'b0100;
  localparam logic [3:0] P3 = 4'b0010;
  localparam logic [3:0] P4 = 4'b0001;

  localparam int EV_GNT  = 0;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  localparam int M_NOM   = 0;
  localparam int M_STALL = 1;
  localparam int M_SKIP  = 2;
  localparam int M_MULTI = 3;

  typedef struct {
    int kind;
    int idx;
    int glen;
    int slen;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [3:0] done;
  logic [1:0] owner_id;
  logic       seq_start;
  logic [3:0] seq_phase;
  logic       busy;
  logic       err;
  logic       err_clr = 1'b0;

  int  checks = 0;
  int  errors = 0;
  int  ptr = 0;
  int  mode = M_NOM;
  ev_t exp_q[$];

  seq_sched_rr #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .done      (done),
    .owner_id  (owner_id),
    .seq_start (seq_start),
    .seq_phase (seq_phase),
    .busy      (busy),
    .err       (err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic int onehot_idx(input logic [3:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference arbiter: first requester at or after ptr, going around the ring.
  function automatic int model_winner(input logic [3:0] r);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (ptr + k) % N;
      if (r[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic expect_ev(input int kind, input int idx, input int glen, input int slen);
    ev_t e;
    e.kind = kind;
    e.idx  = idx;
    e.glen = glen;
    e.slen = slen;
    exp_q.push_back(e);
  endtask

  task automatic observe(input int kind, input int idx, input int glen, input int slen);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d idx %0d, expected no event (t=%0t)", kind, idx, $time);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_idx", idx, e.idx);
      if (e.kind == EV_DONE) check("owner_at_done", int'(owner_id), e.idx);
      if (e.glen >= 0) check("gnt_cycles", glen, e.glen);
      if (e.slen >= 0) check("start_cycles", slen, e.slen);
    end
  endtask

  // Behavioural sequencer: picks up start, then walks P2,P3,P4,P1 one step per clock.
  initial begin
    int   k;
    logic st;
    k = 0;
    seq_phase = P1;
    forever begin
      @(negedge clk);
      st = seq_start;
      @(posedge clk);
      #1;
      if (reset) begin
        k = 0;
        seq_phase = P1;
      end else if (k == 0) begin
        if (st && mode != M_STALL) begin
          k = 1;
          seq_phase = P2;
        end else begin
          seq_phase = P1;
        end
      end else if (k == 1) begin
        if (mode == M_SKIP) begin
          seq_phase = P4;
          k = 0;
        end else if (mode == M_MULTI) begin
          seq_phase = 4'b0110;
          k = 0;
        end else begin
          seq_phase = P3;
          k = 2;
        end
      end else if (k == 2) begin
        seq_phase = P4;
        k = 3;
      end else begin
        seq_phase = P1;
        k = 0;
      end
    end
  end

  // Monitor: turns DUT output activity into events and checks cycle-level invariants.
  initial begin
    logic [3:0] pg;
    logic       perr;
    int         glen;
    int         slen;
    pg = '0;
    perr = 1'b0;
    glen = 0;
    slen = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pg = '0;
        perr = 1'b0;
        glen = 0;
        slen = 0;
      end else begin
        check("busy_vs_gnt", int'(busy), int'(gnt != 0));
        check("gnt_onehot", int'($countones(gnt) <= 1), 1);
        if (gnt != 0) begin
          if (pg == 0) begin
            glen = 0;
            slen = 0;
            observe(EV_GNT, onehot_idx(gnt), -1, -1);
          end
          glen++;
          if (seq_start) slen++;
        end
        if (done != 0) observe(EV_DONE, onehot_idx(done), glen, slen);
        if (err && !perr) observe(EV_ERR, int'(owner_id), glen, slen);
        pg = gnt;
        perr = err;
      end
    end
  end

  task automatic wait_done();
    bit got;
    got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      err_clr = 1'b0;
      if (done != 0) got = 1;
    end
    check("done_seen", int'(got), 1);
  endtask

  // One nominal operation starting from IDLE at a negedge.
  task automatic do_op(input logic [3:0] r, input bit drop);
    int w;
    w = model_winner(r);
    expect_ev(EV_GNT, w, -1, -1);
    expect_ev(EV_DONE, w, 5, 2);
    req = r;
    @(negedge clk);
    check("grant_latency", int'(gnt != 0), 1);
    if (drop) req = '0;
    err_clr = 1'($urandom_range(0, 1));
    wait_done();
    ptr = (w + 1) % N;
  endtask

  // Operation that must end in ERROR, then clear; optionally a request pending across the clear.
  task automatic do_bad(input int m, input logic [3:0] r, input int gl, input int sl, input logic [3:0] pend);
    int w;
    bit got;
    w = model_winner(r);
    expect_ev(EV_GNT, w, -1, -1);
    expect_ev(EV_ERR, w, gl, sl);
    mode = m;
    req = r;
    got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (err) got = 1;
    end
    check("err_seen", int'(got), 1);
    check("err_gnt", int'(gnt), 0);
    check("err_busy", int'(busy), 0);
    check("err_start", int'(seq_start), 0);
    mode = M_NOM;
    req = pend;
    repeat (3) @(negedge clk);
    check("err_sticky", int'(err), 1);
    if (pend != 0) begin
      w = model_winner(pend);
      expect_ev(EV_GNT, w, -1, -1);
      expect_ev(EV_DONE, w, 5, 2);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_cleared", int'(err), 0);
    check("clear_only_no_gnt", int'(gnt), 0);
    if (pend != 0) begin
      @(negedge clk);
      check("grant_after_clear", int'(gnt != 0), 1);
      wait_done();
      ptr = (w + 1) % N;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int w;
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_gnt", int'(gnt), 0);
    check("rst_done", int'(done), 0);
    check("rst_owner", int'(owner_id), 0);
    check("rst_start", int'(seq_start), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err), 0);
    reset = 1'b0;

    // Single request, then owner_id must stay on the last owner.
    do_op(4'b0010, 1'b0);
    req = '0;
    @(negedge clk);
    check("owner_kept", int'(owner_id), 1);

    // Contention with all requesters held, back-to-back.
    for (int i = 0; i < 4; i++) do_op(4'b1111, 1'b0);

    // Wrap-around cases.
    do_op(4'b1000, 1'b0);
    do_op(4'b1001, 1'b0);
    do_op(4'b0001, 1'b0);
    req = '0;
    @(negedge clk);

    // Stall at P1 with a request pending across the clear; then illegal phases in RUN.
    do_bad(M_STALL, 4'b0100, TO, TO, 4'b1000);
    req = '0;
    @(negedge clk);
    do_bad(M_SKIP, 4'b0010, 3, 2, 4'b0000);
    do_bad(M_MULTI, 4'b1011, 3, 2, 4'b0000);

    // Reset in the middle of RUN at P3.
    w = model_winner(4'b0100);
    expect_ev(EV_GNT, w, -1, -1);
    req = 4'b0100;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (seq_phase == P3) got = 1;
    end
    check("reached_p3", int'(got), 1);
    reset = 1'b1;
    #1;
    check("midrst_gnt", int'(gnt), 0);
    check("midrst_start", int'(seq_start), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    req = '0;
    ptr = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    do_op(4'b0100, 1'b0);

    // Randomized operations, some dropping req mid-operation.
    repeat (30) do_op(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
    req = '0;

    repeat (5) @(negedge clk);
    check("events_pending", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
